// File: rtl/sar_adc_ctrl_if.sv
// Request/result bundle between the SAR sequencer and its user, plus the
// trial-code / comparator loop to the external ladder and op-amp comparator.
interface sar_adc_ctrl_if #(
  parameter int WIDTH    = 8,
  parameter int SETTLE_W = 4
);
  logic                start;
  logic [SETTLE_W-1:0] settle_cycles;
  logic                cmp_in;
  logic [WIDTH-1:0]    dac_code;
  logic [WIDTH-1:0]    result;
  logic                busy;
  logic                done;

  modport master (
    output start, settle_cycles, cmp_in,
    input  dac_code, result, busy, done
  );

  modport slave (
    input  start, settle_cycles, cmp_in,
    output dac_code, result, busy, done
  );
endinterface

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation sequencer: drives trial codes onto an external
// R-2R ladder and resolves one bit per settle window from the comparator.
module sar_adc_ctrl #(
  parameter int WIDTH    = 8,
  parameter int SETTLE_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  sar_adc_ctrl_if.slave  bus
);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_DECIDE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]          state_reg;
  logic [WIDTH-1:0]    dac_reg;
  logic [WIDTH-1:0]    result_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [SETTLE_W-1:0] cnt_reg;
  logic [SETTLE_W-1:0] settle_reg;
  logic [1:0]          sync_reg;
  logic                cmp_sync;
  logic [SETTLE_W-1:0] settle_eff;
  logic [WIDTH-1:0]    decide_code;

  assign cmp_sync   = sync_reg[1];
  // A zero setting would leave the 2-flop synchronizer latency uncovered.
  assign settle_eff = (bus.settle_cycles == '0) ? SETTLE_W'(1) : bus.settle_cycles;

  // Code after resolving the current bit and, if any remain, trying the next.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_decide
      if (gi < WIDTH - 1) begin : g_lower
        always_comb begin
          decide_code[gi] = dac_reg[gi];
          if (idx_reg == IDX_W'(gi))
            decide_code[gi] = dac_reg[gi] & cmp_sync;
          else if (idx_reg == IDX_W'(gi + 1))
            decide_code[gi] = 1'b1;
        end
      end else begin : g_top
        always_comb begin
          decide_code[gi] = dac_reg[gi];
          if (idx_reg == IDX_W'(gi))
            decide_code[gi] = dac_reg[gi] & cmp_sync;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], bus.cmp_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      dac_reg    <= '0;
      result_reg <= '0;
      idx_reg    <= IDX_W'(WIDTH - 1);
      cnt_reg    <= '0;
      settle_reg <= '0;
    end else if (!ena) begin
      // Abort: dac_code and result are left exactly as they were.
      state_reg <= ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            settle_reg <= settle_eff;
            cnt_reg    <= settle_eff;
            dac_reg    <= {1'b1, {(WIDTH-1){1'b0}}};
            idx_reg    <= IDX_W'(WIDTH - 1);
            state_reg  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt_reg == '0)
            state_reg <= ST_DECIDE;
          else
            cnt_reg <= cnt_reg - 1'b1;
        end
        ST_DECIDE: begin
          dac_reg <= decide_code;
          if (idx_reg == '0) begin
            result_reg <= decide_code;
            state_reg  <= ST_DONE;
          end else begin
            idx_reg   <= idx_reg - 1'b1;
            cnt_reg   <= settle_reg;
            state_reg <= ST_SETTLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.dac_code = dac_reg;
  assign bus.result   = result_reg;
  assign bus.busy     = (state_reg == ST_SETTLE) || (state_reg == ST_DECIDE);
  assign bus.done     = (state_reg == ST_DONE);
endmodule

// File: doc/sar_adc_ctrl.md
Name: sar_adc_ctrl

Overview:
- Digital successive-approximation sequencer wrapped around the analog op-amp stage, with the op-amp run open-loop as a comparator.
- Upstream, it drives a trial code onto uo_out. An external R-2R ladder turns that code into the voltage on the comparator MINUS pin.
- Downstream, it consumes the comparator output (VOUT routed back in on ui_in[0]) and produces a WIDTH-bit conversion result.
- It sits in a digital tile next to the op-amp macro and shares the chip's clk, rst_n and ena.

Parameters:
- WIDTH, 8, resolution in bits of the trial code and the result.
- SETTLE_W, 4, width of the settle-time configuration input.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- ena  input  1  design enable; low aborts and holds the block idle.
- start  input  1  level request; a conversion begins when sampled high in IDLE.
- settle_cycles  input  SETTLE_W  extra DAC settle cycles per bit; latched at start.
- cmp_in  input  1  raw asynchronous comparator output; 1 means Vin >= Vdac.
- dac_code  output  WIDTH  trial code driving the external ladder.
- result  output  WIDTH  last completed conversion.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when result updates.

Behaviour:
- Reset (async, rst_n low): state=IDLE; dac_code=0, result=0, busy=0, done=0; synchronizer flops=0; bit index=WIDTH-1; settle counter=0.
- Synchronizer: cmp_in passes through 2 flops to give cmp_sync. Only cmp_sync is used.
- Effective settle S = max(settle_cycles, 1). It is latched on the start edge so that the 2-flop latency is always covered.
- States: IDLE, SETTLE, DECIDE, DONE.
- IDLE:
  - busy=0; dac_code holds its last value.
  - If ena & start: latch S; dac_code = 1<<(WIDTH-1), all other bits 0; bit index=WIDTH-1; counter=S; go to SETTLE.
- SETTLE:
  - busy=1; counter decrements each cycle.
  - When counter==0, go to DECIDE. SETTLE therefore lasts S+1 cycles.
- DECIDE (1 cycle), busy=1:
  - If cmp_sync==0, clear dac_code[index]; otherwise keep it.
  - If index==0: result <= final dac_code; go to DONE.
  - Else: index--, set dac_code[index-1]=1, counter=S, go to SETTLE.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then go to IDLE.
  - dac_code equals result.
- Latency: done is high during the cycle following clock edge WIDTH*(S+2), counted from the edge that accepted start (edge 0).
- Back-to-back: if start is still high when the block returns to IDLE, the next conversion is accepted on the IDLE cycle. Minimum gap between done pulses is WIDTH*(S+2)+2 cycles.
- start while busy or in DONE: ignored.
- ena low in any state:
  - Next edge forces IDLE, busy=0.
  - No done pulse; result is unchanged; dac_code holds its value at abort.
- settle_cycles changing mid-conversion has no effect until the next start.
- Async reset mid-conversion: all outputs return to reset values immediately, with no done pulse.
- All arithmetic is unsigned. The bit index is never decremented below 0.

Test Plan:
1. Reset, WIDTH=8, settle_cycles=3; bench comparator model cmp_in=(0xA5 >= dac_code), combinational. Pulse start -> busy high; done pulses 40 edges after start; result=0xA5, dac_code=0xA5.
2. Full-scale: model input 0x00, then 0xFF, settle_cycles=1 -> result=0x00 in 24 cycles, then 0xFF. No wrap; busy is low when done fires.
3. settle_cycles=0 with input 0x3C -> timing identical to settle_cycles=1 (24 cycles); result=0x3C.
4. Hold start high continuously with input 0x5A then 0x81, settle_cycles=2 -> consecutive done pulses exactly 34 cycles apart; results 0x5A then 0x81.
5. Drop ena for 1 cycle at cycle 10 of a conversion (input 0x77) -> busy falls the next cycle; no done; result keeps its previous value. The next start gives 0x77.
6. Assert rst_n low mid-conversion, and toggle start and settle_cycles while busy -> outputs are 0 immediately on reset. While busy, extra starts and the new settle value do not change timing or result.
